// File: rtl/tw_pkg.sv
// rtl/tw_pkg.sv - shared encodings and defaults for the three-wire arbiter
package tw_pkg;

    // FSM state encoding
    localparam logic [2:0] TW_IDLE      = 3'd0;
    localparam logic [2:0] TW_START     = 3'd1;
    localparam logic [2:0] TW_WAIT_BUSY = 3'd2;
    localparam logic [2:0] TW_WAIT_DONE = 3'd3;
    localparam logic [2:0] TW_COMPLETE  = 3'd4;

    // Default bus geometry of the three-wire master
    localparam int TW_DEF_ADDR_BITS = 9;
    localparam int TW_DEF_DATA_BITS = 16;

    // Operation codes carried on the mode line
    localparam logic TW_OP_READ  = 1'b0;
    localparam logic TW_OP_WRITE = 1'b1;

endpackage

// File: rtl/tw_rr_select.sv
// rtl/tw_rr_select.sv - combinational round-robin picker
module tw_rr_select
    import tw_pkg::*;
#(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   last_i,
    output logic [NUM_REQ-1:0] grant_o,
    output logic [IDX_W-1:0]   idx_o,
    output logic               valid_o
);

    // Walk forward from the slot after the previous winner; the first active requester wins.
    always_comb begin
        logic [IDX_W-1:0] cand;
        logic             found;
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        cand    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            cand = IDX_W'((int'(last_i) + off) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found          = 1'b1;
                grant_o[cand]  = 1'b1;
                idx_o          = cand;
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/tw_arbiter.sv
// rtl/tw_arbiter.sv - round-robin arbiter sharing one three-wire master
module tw_arbiter
    import tw_pkg::*;
#(
    parameter int NUM_REQ       = 2,
    parameter int ADDR_BITS     = TW_DEF_ADDR_BITS,
    parameter int DATA_BITS     = TW_DEF_DATA_BITS,
    parameter int START_TIMEOUT = 15
) (
    input  logic                           in_clk,
    input  logic                           in_rst,
    input  logic [NUM_REQ-1:0]             in_req,
    input  logic [NUM_REQ-1:0]             in_mode_wr,
    input  logic [NUM_REQ*ADDR_BITS-1:0]   in_addr,
    input  logic [NUM_REQ*DATA_BITS-1:0]   in_wr_data,
    output logic [NUM_REQ-1:0]             out_grant,
    output logic [NUM_REQ-1:0]             out_done,
    output logic                           out_error,
    output logic [DATA_BITS-1:0]           out_rd_data,
    output logic                           out_tw_start,
    output logic                           out_tw_mode_wr,
    output logic [ADDR_BITS-1:0]           out_tw_addr,
    output logic [DATA_BITS-1:0]           out_tw_wr_data,
    input  logic [DATA_BITS-1:0]           in_tw_rd_data,
    input  logic                           in_tw_in_progress
);

    localparam int IDX_W = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(START_TIMEOUT + 1);

    logic [2:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [IDX_W-1:0]     last_q, last_d;
    logic                 timeout_hit;

    logic [NUM_REQ-1:0]   grant_q, grant_d;
    logic [NUM_REQ-1:0]   done_q, done_d;
    logic                 error_q, error_d;
    logic [DATA_BITS-1:0] rd_data_q, rd_data_d;
    logic                 start_q, start_d;
    logic                 mode_q, mode_d;
    logic [ADDR_BITS-1:0] addr_q, addr_d;
    logic [DATA_BITS-1:0] wr_data_q, wr_data_d;

    logic [NUM_REQ-1:0]   sel_grant;
    logic [IDX_W-1:0]     sel_idx;
    logic                 sel_valid;

    tw_rr_select #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_rr_select (
        .req_i   (in_req),
        .last_i  (last_q),
        .grant_o (sel_grant),
        .idx_o   (sel_idx),
        .valid_o (sel_valid)
    );

    // State, counter, round-robin pointer and all output registers.
    always_ff @(posedge in_clk or posedge in_rst) begin
        if (in_rst) begin
            state_q   <= TW_IDLE;
            cnt_q     <= '0;
            last_q    <= IDX_W'(NUM_REQ - 1);
            grant_q   <= '0;
            done_q    <= '0;
            error_q   <= 1'b0;
            rd_data_q <= '0;
            start_q   <= 1'b0;
            mode_q    <= 1'b0;
            addr_q    <= '0;
            wr_data_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            last_q    <= last_d;
            grant_q   <= grant_d;
            done_q    <= done_d;
            error_q   <= error_d;
            rd_data_q <= rd_data_d;
            start_q   <= start_d;
            mode_q    <= mode_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
        end
    end

    // Next-state logic: arbitration, start handshake, busy wait with a saturating timeout.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        timeout_hit = 1'b0;
        case (state_q)
            TW_IDLE: begin
                if (sel_valid) begin
                    state_d = TW_START;
                    last_d  = sel_idx;
                end
            end
            TW_START: begin
                state_d = TW_WAIT_BUSY;
                cnt_d   = '0;
            end
            TW_WAIT_BUSY: begin
                if (in_tw_in_progress) begin
                    state_d = TW_WAIT_DONE;
                end else begin
                    if (cnt_q != CNT_W'(START_TIMEOUT)) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (cnt_q >= CNT_W'(START_TIMEOUT - 1)) begin
                        state_d     = TW_COMPLETE;
                        timeout_hit = 1'b1;
                    end
                end
            end
            TW_WAIT_DONE: begin
                if (!in_tw_in_progress) begin
                    state_d = TW_COMPLETE;
                end
            end
            TW_COMPLETE: begin
                state_d = TW_IDLE;
            end
            default: begin
                state_d = TW_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Next values of the registered outputs, decided from the transition being taken.
    always_comb begin
        grant_d   = grant_q;
        done_d    = '0;
        error_d   = 1'b0;
        rd_data_d = rd_data_q;
        start_d   = 1'b0;
        mode_d    = mode_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            TW_IDLE: begin
                if (sel_valid) begin
                    grant_d   = sel_grant;
                    start_d   = 1'b1;
                    mode_d    = in_mode_wr[sel_idx] ? TW_OP_WRITE : TW_OP_READ;
                    addr_d    = in_addr[int'(sel_idx)*ADDR_BITS +: ADDR_BITS];
                    wr_data_d = in_wr_data[int'(sel_idx)*DATA_BITS +: DATA_BITS];
                end
            end
            TW_START: begin
            end
            TW_WAIT_BUSY: begin
                if (timeout_hit) begin
                    done_d    = grant_q;
                    error_d   = 1'b1;
                    rd_data_d = '0;
                end
            end
            TW_WAIT_DONE: begin
                if (!in_tw_in_progress) begin
                    done_d    = grant_q;
                    rd_data_d = (mode_q == TW_OP_READ) ? in_tw_rd_data : '0;
                end
            end
            TW_COMPLETE: begin
                grant_d = '0;
            end
            default: begin
                grant_d   = '0;
                rd_data_d = '0;
                mode_d    = 1'b0;
                addr_d    = '0;
                wr_data_d = '0;
            end
        endcase
    end

    assign out_grant      = grant_q;
    assign out_done       = done_q;
    assign out_error      = error_q;
    assign out_rd_data    = rd_data_q;
    assign out_tw_start   = start_q;
    assign out_tw_mode_wr = mode_q;
    assign out_tw_addr    = addr_q;
    assign out_tw_wr_data = wr_data_q;

endmodule
